// File: rtl/uart_pkg.sv
// Shared widths, FSM state encoding and the frame parity rule for the UART loopback.
// Defining UART_ODD_PARITY_EN switches the parity bit and its check to odd parity.
package uart_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Zero-extension is harmless: extra zero bits change neither XOR nor XNOR.
    function automatic logic parity_bit(input logic [31:0] d);
`ifdef UART_ODD_PARITY_EN
        return ~^d;
`else
        return ^d;
`endif
    endfunction

endpackage

// File: rtl/uart_loopback_top_fifo.sv
// Tick-paced synchronous FIFO; the extra pointer bit separates full from empty.
// Used both as the TX FIFO and the RX FIFO of the loopback.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          en,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign do_wr = en && wr && !full;
    assign do_rd = en && rd && !empty;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_loopback_top.sv
// UART loopback: TX FIFO -> transmitter -> serial line -> receiver -> RX FIFO, all on one baud tick.
// Optional macro UART_ODD_PARITY_EN selects odd parity (even parity when undefined).
module uart_loopback_top
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 100,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          strt_enbl,
    input  logic [DW-1:0] din,
    input  logic          write_en,
    input  logic          p_enbl,
    output logic          error
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DW);

    logic [CW-1:0] baud_cnt;
    logic          tx_enbl;

    always_ff @(posedge clk) begin
        if (areset)       baud_cnt <= '0;
        else if (tx_enbl) baud_cnt <= '0;
        else              baud_cnt <= baud_cnt + CW'(1);
    end

    assign tx_enbl = (baud_cnt == CW'(CLK_DIV - 1));

    logic [DW-1:0] tx_head;
    logic          tx_full;
    logic          tx_empty;
    logic [DW-1:0] rx_head;
    logic          rx_full;
    logic          rx_empty;
    logic          ack;
    logic          nack;

    // The read pointer only moves on ack, so a nacked byte stays at the head for resend.
    uart_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .areset(areset),
        .en    (tx_enbl),
        .wr    (write_en),
        .wdata (din),
        .rd    (ack),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    state_t        tx_state;
    state_t        tx_next;
    logic [DW-1:0] tx_shreg;
    logic [BW-1:0] tx_idx;
    logic          tx_par_en;
    logic          tx_load;
    logic          line;
    logic          busy;

    always_ff @(posedge clk) begin
        if (areset) tx_state <= IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        line    = 1'b1;
        tx_load = 1'b0;
        case (tx_state)
            IDLE: begin
                if (tx_enbl && strt_enbl && !tx_empty) begin
                    tx_next = START;
                    tx_load = 1'b1;
                end
            end
            START: begin
                line = 1'b0;
                if (tx_enbl) tx_next = DATA;
            end
            DATA: begin
                line = tx_shreg[tx_idx];
                if (tx_enbl && tx_idx == BW'(DW - 1)) tx_next = tx_par_en ? PARITY : STOP;
            end
            PARITY: begin
                line = parity_bit(32'(tx_shreg));
                if (tx_enbl) tx_next = STOP;
            end
            STOP: begin
                if (tx_enbl) tx_next = IDLE;
            end
            default: tx_next = IDLE;
        endcase
    end

    assign busy = (tx_state != IDLE);

    always_ff @(posedge clk) begin
        if (areset) begin
            tx_shreg  <= '0;
            tx_idx    <= '0;
            tx_par_en <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_shreg  <= tx_head;
                tx_par_en <= p_enbl;
            end
            if (tx_enbl) tx_idx <= (tx_state == DATA) ? tx_idx + BW'(1) : '0;
        end
    end

    // Receiver samples on the same ticks as the transmitter, one slot behind the line change.
    logic          info;
    state_t        rx_state;
    state_t        rx_next;
    logic [DW-1:0] rx_shreg;
    logic [BW-1:0] rx_idx;
    logic          rx_par;
    logic          frame_ok;

    assign info = line;

    always_ff @(posedge clk) begin
        if (areset) rx_state <= IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:    if (tx_enbl && !info) rx_next = DATA;
            DATA:    if (tx_enbl && rx_idx == BW'(DW - 1)) rx_next = tx_par_en ? PARITY : STOP;
            PARITY:  if (tx_enbl) rx_next = STOP;
            STOP:    if (tx_enbl) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    // A stop bit sampled low is rejected exactly like a parity mismatch.
    assign frame_ok = info && (!tx_par_en || (rx_par == parity_bit(32'(rx_shreg))));
    assign ack      = tx_enbl && (rx_state == STOP) && frame_ok;
    assign nack     = tx_enbl && (rx_state == STOP) && !frame_ok;

    always_ff @(posedge clk) begin
        if (areset) begin
            rx_shreg <= '0;
            rx_idx   <= '0;
            rx_par   <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (tx_enbl) begin
                case (rx_state)
                    DATA: begin
                        rx_shreg <= {info, rx_shreg[DW-1:1]};
                        rx_idx   <= rx_idx + BW'(1);
                    end
                    PARITY:  rx_par <= info;
                    default: rx_idx <= '0;
                endcase
            end
            if (ack)       error <= 1'b0;
            else if (nack) error <= 1'b1;
        end
    end

    uart_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .areset(areset),
        .en    (tx_enbl),
        .wr    (ack),
        .wdata (rx_shreg),
        .rd    (1'b0),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Status nets kept for observation; nothing inside the block consumes them.
    logic status_unused;
    assign status_unused = ^{rx_head, rx_full, rx_empty, tx_full, busy};

endmodule

// File: tb/tb_uart_loopback_top.sv
// Randomized directed bench for uart_loopback_top against a queue-based frame/FIFO model.
module tb_uart_loopback_top;
    localparam int CDIV  = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       areset;
    logic       strt_enbl;
    logic [7:0] din;
    logic       write_en;
    logic       p_enbl;
    logic       error;

    int checks = 0;
    int passes = 0;

    byte unsigned tx_q[$];
    byte unsigned rx_q[$];
    logic         exp_err;
    logic [7:0]   wbytes [18] = '{8'h23, 8'h33, 8'h43, 8'h53, 8'h63, 8'h01, 8'h12, 8'h24, 8'h33,
                                  8'h46, 8'h77, 8'h81, 8'h13, 8'h15, 8'h67, 8'h69, 8'h96, 8'h66};

    uart_loopback_top #(.CLK_DIV(CDIV), .DEPTH(DEPTH), .DW(8)) dut (
        .clk      (clk),
        .areset   (areset),
        .strt_enbl(strt_enbl),
        .din      (din),
        .write_en (write_en),
        .p_enbl   (p_enbl),
        .error    (error)
    );

    always #5 clk = ~clk;

    function automatic logic ref_par(input logic [7:0] d);
`ifdef UART_ODD_PARITY_EN
        return ~^d;
`else
        return ^d;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to #1 after the next baud-tick edge; a missing tick counts as a failure.
    task automatic do_tick();
        int n;
        n = 0;
        while (dut.tx_enbl !== 1'b1 && n < 8 * CDIV) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8 * CDIV) begin
            checks++;
            $error("FAIL tick_timeout: observed no tick within %0d cycles", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic pe, input bit corrupt, input bit poke_busy,
                              input bit wr_last, input logic [7:0] wbyte);
        logic [7:0] d;
        logic       bits[$];
        int         last;
        d = tx_q[0];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(ref_par(d));
        bits.push_back(1'b1);
        last = bits.size() - 1;

        strt_enbl = 1'b1;
        p_enbl    = pe;
        do_tick();
        strt_enbl = 1'b0;
        p_enbl    = 1'($urandom);
        for (int k = 0; k <= last; k++) begin
            check($sformatf("line_%02h_slot%0d", d, k), 32'(dut.line), 32'(bits[k]));
            if (k == 0) check("busy_in_frame", 32'(dut.busy), 1);
            if (poke_busy) strt_enbl = (k == 3);
            if (wr_last && k == last) begin
                write_en = 1'b1;
                din      = wbyte;
            end
            if (corrupt && k == 9) begin
                if (bits[9]) force dut.info = 1'b0;
                else         force dut.info = 1'b1;
            end
            do_tick();
            if (corrupt && k == 9) release dut.info;
        end
        write_en  = 1'b0;
        strt_enbl = 1'b0;

        // Write is judged against the pre-pop occupancy, then the pop (if acked) applies.
        if (wr_last && tx_q.size() < DEPTH) tx_q.push_back(wbyte);
        if (corrupt) begin
            exp_err = 1'b1;
        end else begin
            void'(tx_q.pop_front());
            if (rx_q.size() < DEPTH) rx_q.push_back(d);
            exp_err = 1'b0;
        end
        check("line_after_frame", 32'(dut.line), 1);
        check("busy_after_frame", 32'(dut.busy), 0);
        check($sformatf("error_after_%02h", d), 32'(error), 32'(exp_err));
        check("rx_count", 32'(dut.u_rx_fifo.wr_ptr), 32'(rx_q.size()));
        if (rx_q.size() > 0)
            check("rx_tail", 32'(dut.u_rx_fifo.mem[rx_q.size() - 1]), 32'(rx_q[rx_q.size() - 1]));
    endtask

    initial begin
        areset    = 1'b1;
        strt_enbl = 1'b0;
        din       = 8'h00;
        write_en  = 1'b0;
        p_enbl    = 1'b0;
        exp_err   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        check("rst_error", 32'(error), 0);
        check("rst_line", 32'(dut.line), 1);
        check("rst_busy", 32'(dut.busy), 0);
        check("rst_tx_empty", 32'(dut.tx_empty), 1);
        check("rst_rx_empty", 32'(dut.rx_empty), 1);

        // 18 writes on successive ticks: the last two must be dropped.
        for (int i = 0; i < 18; i++) begin
            write_en = 1'b1;
            din      = wbytes[i];
            do_tick();
            if (tx_q.size() < DEPTH) tx_q.push_back(wbytes[i]);
        end
        write_en = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("tx_mem%0d", i), 32'(dut.u_tx_fifo.mem[i]), 32'(tx_q[i]));
        check("tx_full", 32'(dut.tx_full), 1);

        send_frame(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) do_tick();
            send_frame(1'b1, 1'b0, i == 2, 1'b0, 8'h00);
        end

        // Parity slot of 0x77 corrupted: nack, then the same byte goes out again.
        send_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("head_still_77", 32'(dut.u_tx_fifo.rdata), 32'h77);
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        while (tx_q.size() > 0) begin
            repeat ($urandom_range(0, 3)) do_tick();
            send_frame(1'($urandom), 1'b0, 1'($urandom), 1'b0, 8'h00);
        end
        check("rx_full", 32'(dut.u_rx_fifo.full), 1);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("rx_mem%0d", i), 32'(dut.u_rx_fifo.mem[i]), 32'(rx_q[i]));

        // Start requests with nothing queued must leave the line idle.
        strt_enbl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check("empty_start_line", 32'(dut.line), 1);
            check("empty_start_busy", 32'(dut.busy), 0);
        end
        strt_enbl = 1'b0;

        // Random tail: RX is full, so good frames are acked but not stored.
        for (int i = 0; i < 3; i++) begin
            write_en = 1'b1;
            din      = 8'($urandom);
            do_tick();
            tx_q.push_back(din);
        end
        write_en = 1'b0;
        send_frame(1'($urandom), 1'b0, 1'b0, 1'b1, 8'($urandom));
        send_frame(1'($urandom), 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("tx_not_empty", 32'(dut.tx_empty), 0);

        // Reset in the middle of the data bits of the resend.
        strt_enbl = 1'b1;
        p_enbl    = 1'b1;
        do_tick();
        strt_enbl = 1'b0;
        do_tick();
        do_tick();
        check("mid_busy", 32'(dut.busy), 1);
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        tx_q.delete();
        rx_q.delete();
        check("arst_line", 32'(dut.line), 1);
        check("arst_busy", 32'(dut.busy), 0);
        check("arst_tx_empty", 32'(dut.tx_empty), 1);
        check("arst_rx_empty", 32'(dut.rx_empty), 1);
        check("arst_error", 32'(error), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
